msrv32_dmem_access_ctrl: RTL and testbench
==========================================

Name: msrv32_dmem_access_ctrl

Overview:
Sequences every data-memory load and store issued by the msrv32 pipeline onto the AHB-lite style data bus.
- Checks natural alignment.
- Generates the word-aligned address, the byte write mask and lane-replicated store data.
- Holds the pipeline stalled through address and data phases, including wait states.
- Registers size, offset and signedness so the load unit can align and extend the returned data word.
- Reports bus errors, response timeouts and misaligned accesses.

Parameters:
TIMEOUT_CYC, 16, wait cycles allowed in ADDR+DATA before a transaction is aborted as a bus error (min 2)
CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYC

Ports:
ms_riscv32_mp_clk_in  in  1  clock, all state on rising edge
ms_riscv32_mp_rst_in  in  1  reset, asynchronous, active-high
ld_req_in  in  1  load request from pipeline, sampled in IDLE only
st_req_in  in  1  store request from pipeline, sampled in IDLE only
iadder_in  in  32  effective byte address
size_in  in  2  00 byte, 01 half, 10/11 word
unsigned_in  in  1  zero-extend load
st_data_in  in  32  store data, right-justified
dm_ready_in  in  1  bus ready (phase complete)
dm_resp_in  in  1  bus error response, valid with dm_ready_in in DATA
dm_addr_out  out  32  word-aligned bus address
dm_req_out  out  1  address-phase valid
dm_wr_out  out  1  1 = write transfer
dm_wr_mask_out  out  4  byte write enables
dm_wdata_out  out  32  lane-replicated store data
lu_size_out  out  2  registered size for load unit
lu_offset_out  out  2  registered iadder_in[1:0] for load unit
lu_unsigned_out  out  1  registered unsigned flag for load unit
lu_valid_out  out  1  one-cycle pulse: bus read data valid this cycle
stall_out  out  1  freeze pipeline
misaligned_out  out  1  one-cycle pulse, misaligned request rejected
bus_err_out  out  1  one-cycle pulse, error response or timeout

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE and the counter clears.
  - Every output, registered or combinational, is 0.
  - The in-flight transfer is abandoned and no pulse is generated.
- FSM has three states: IDLE, ADDR and DATA.
- IDLE, no request: all request-phase outputs are 0 and stall_out=0.
- IDLE, request present:
  - If st_req_in and ld_req_in are both high, the store wins and the load is dropped.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned request: misaligned_out=1 next cycle, no bus activity, state stays IDLE, stall_out=0.
  - Aligned request: registers load on the edge and the state goes to ADDR:
    - dm_addr_out={iadder_in[31:2],2'b00}, dm_req_out=1, dm_wr_out=st_req_in.
    - lu_size_out/lu_offset_out/lu_unsigned_out are captured.
  - stall_out is 1 combinationally in the accepting cycle.
- Write mask:
  - Byte: 4'b0001<<offset.
  - Half: 4'b0011<<(2*offset[1]).
  - Word: 4'b1111.
  - Loads: 4'b0000.
- Write data:
  - Byte: {4{d[7:0]}}.
  - Half: {2{d[15:0]}}.
  - Word: d.
- ADDR:
  - All bus outputs are held stable.
  - On dm_ready_in=1: go to DATA, clear dm_req_out; dm_addr/wr/mask/wdata stay held.
- DATA:
  - On dm_ready_in=1 with dm_resp_in=1: bus_err_out pulses and the state goes to IDLE.
  - On dm_ready_in=1 otherwise: a load pulses lu_valid_out in the same cycle (combinational), then the state goes to IDLE.
- Timeout:
  - The counter clears on accept and increments each cycle in ADDR/DATA.
  - When it reaches TIMEOUT_CYC-1 without completion, bus_err_out pulses next cycle, the state goes to IDLE and the bus outputs clear.
- stall_out=1 in ADDR and DATA.
- Requests arriving outside IDLE are ignored.
- lu_* outputs hold until the next accepted request.
- Minimum latency:
  - Accept, then 1 cycle in ADDR, then 1 cycle in DATA.
  - This gives 3 stall cycles with zero wait states.

Decomposition:
- msrv32_pkg holds:
  - Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
  - FSM state encodings.
  - Timeout default.
- Sub-module msrv32_store_lane_gen holds the combinational mask and write-data generation from size, offset and data.

Test Plan:
- Word store, addr 0x100, data 0xDEADBEEF, ready always 1 -> dm_addr 0x100, mask 1111, wdata 0xDEADBEEF, stall 3 cycles, no pulses.
- Byte store, addr 0x203, data 0x000000A5 -> mask 1000, wdata 0xA5A5A5A5, dm_addr 0x200.
- Half load, addr 0x302, unsigned=1, ready low 2 cycles in DATA -> lu_offset=2, lu_size=01, lu_unsigned=1, lu_valid pulses once on the ready cycle, stall held throughout.
- Word load, addr 0x401 -> misaligned_out pulse, dm_req_out never asserts, stall 0.
- Load with ready stuck low -> bus_err_out pulses after TIMEOUT_CYC cycles, then IDLE; a second load with a DATA-phase dm_resp_in=1 -> bus_err_out pulse, lu_valid 0.
- Reset asserted during DATA -> all outputs 0 immediately; a following ld+st simultaneous request -> store transfer only.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared encodings and helpers for the msrv32 data-memory access path.
package msrv32_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int TIMEOUT_CYC_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10
   } dm_state_e;

   // Sizes 10 and 11 both count as word accesses
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = offset[0];
         default: mis = |offset;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/msrv32_store_lane_gen.sv
// Byte-lane write mask and lane-replicated store data for a store of the given size/offset.
module msrv32_store_lane_gen
   import msrv32_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic [31:0] data,
   output logic [3:0]  mask,
   output logic [31:0] wdata
);

   // Replicating the data across lanes lets the mask alone select the written bytes
   always_comb begin
      mask  = 4'b0000;
      wdata = 32'h0000_0000;
      case (size)
         SZ_BYTE: begin
            mask  = 4'b0001 << offset;
            wdata = {4{data[7:0]}};
         end
         SZ_HALF: begin
            mask  = 4'b0011 << {offset[1], 1'b0};
            wdata = {2{data[15:0]}};
         end
         default: begin
            mask  = 4'b1111;
            wdata = data;
         end
      endcase
   end

endmodule

// File: rtl/msrv32_dmem_access_ctrl.sv
// Sequences msrv32 loads/stores onto the AHB-lite style data bus, stalls the pipeline
// while a transfer is in flight and hands size/offset/signedness to the load unit.
module msrv32_dmem_access_ctrl
   import msrv32_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int CNT_W       = 5
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic        ld_req_in,
   input  logic        st_req_in,
   input  logic [31:0] iadder_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   input  logic [31:0] st_data_in,
   input  logic        dm_ready_in,
   input  logic        dm_resp_in,
   output logic [31:0] dm_addr_out,
   output logic        dm_req_out,
   output logic        dm_wr_out,
   output logic [3:0]  dm_wr_mask_out,
   output logic [31:0] dm_wdata_out,
   output logic [1:0]  lu_size_out,
   output logic [1:0]  lu_offset_out,
   output logic        lu_unsigned_out,
   output logic        lu_valid_out,
   output logic        stall_out,
   output logic        misaligned_out,
   output logic        bus_err_out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   dm_state_e        state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [31:0]      dm_addr_r, dm_addr_nxt_s;
   logic             dm_req_r, dm_req_nxt_s;
   logic             dm_wr_r, dm_wr_nxt_s;
   logic [3:0]       dm_mask_r, dm_mask_nxt_s;
   logic [31:0]      dm_wdata_r, dm_wdata_nxt_s;
   logic [1:0]       lu_size_r, lu_size_nxt_s;
   logic [1:0]       lu_offset_r, lu_offset_nxt_s;
   logic             lu_unsigned_r, lu_unsigned_nxt_s;
   logic             misaligned_r, misaligned_nxt_s;
   logic             bus_err_r, bus_err_nxt_s;
   logic             clr_bus_s;

   logic             req_s, misal_s, accept_s, done_s, timeout_s;
   logic [3:0]       lane_mask_s;
   logic [31:0]      lane_wdata_s;

   msrv32_store_lane_gen u_lane_gen (
      .size   (size_in),
      .offset (iadder_in[1:0]),
      .data   (st_data_in),
      .mask   (lane_mask_s),
      .wdata  (lane_wdata_s)
   );

   assign req_s     = ld_req_in | st_req_in;
   assign misal_s   = is_misaligned(size_in, iadder_in[1:0]);
   assign accept_s  = (state_r == ST_IDLE) & req_s & ~misal_s;
   assign done_s    = (state_r == ST_DATA) & dm_ready_in;
   // A DATA-phase completion on the last allowed cycle still wins over the timeout
   assign timeout_s = (state_r != ST_IDLE) & (cnt_r == CNT_LAST) & ~done_s;

   // State and timeout counter register
   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nxt_s = ST_ADDR;
            else          state_nxt_s = ST_IDLE;
         end
         ST_ADDR: begin
            if (timeout_s)        state_nxt_s = ST_IDLE;
            else if (dm_ready_in) state_nxt_s = ST_DATA;
            else                  state_nxt_s = ST_ADDR;
         end
         ST_DATA: begin
            if (done_s | timeout_s) state_nxt_s = ST_IDLE;
            else                    state_nxt_s = ST_DATA;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values for the registered outputs and the counter
   always_comb begin
      dm_addr_nxt_s     = dm_addr_r;
      dm_req_nxt_s      = dm_req_r;
      dm_wr_nxt_s       = dm_wr_r;
      dm_mask_nxt_s     = dm_mask_r;
      dm_wdata_nxt_s    = dm_wdata_r;
      lu_size_nxt_s     = lu_size_r;
      lu_offset_nxt_s   = lu_offset_r;
      lu_unsigned_nxt_s = lu_unsigned_r;
      misaligned_nxt_s  = 1'b0;
      bus_err_nxt_s     = 1'b0;
      cnt_nxt_s         = {CNT_W{1'b0}};
      clr_bus_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               dm_addr_nxt_s     = {iadder_in[31:2], 2'b00};
               dm_req_nxt_s      = 1'b1;
               dm_wr_nxt_s       = st_req_in;
               dm_mask_nxt_s     = st_req_in ? lane_mask_s : 4'b0000;
               dm_wdata_nxt_s    = st_req_in ? lane_wdata_s : 32'h0000_0000;
               lu_size_nxt_s     = size_in;
               lu_offset_nxt_s   = iadder_in[1:0];
               lu_unsigned_nxt_s = unsigned_in;
            end else begin
               misaligned_nxt_s  = req_s;
            end
         end
         ST_ADDR: begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            if (timeout_s) begin
               clr_bus_s     = 1'b1;
               bus_err_nxt_s = 1'b1;
            end else if (dm_ready_in) begin
               dm_req_nxt_s  = 1'b0;
            end else begin
               dm_req_nxt_s  = dm_req_r;
            end
         end
         ST_DATA: begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            if (done_s) begin
               clr_bus_s     = 1'b1;
               bus_err_nxt_s = dm_resp_in;
            end else if (timeout_s) begin
               clr_bus_s     = 1'b1;
               bus_err_nxt_s = 1'b1;
            end else begin
               clr_bus_s     = 1'b0;
            end
         end
         default: clr_bus_s = 1'b1;
      endcase
      if (clr_bus_s) begin
         dm_addr_nxt_s  = 32'h0000_0000;
         dm_req_nxt_s   = 1'b0;
         dm_wr_nxt_s    = 1'b0;
         dm_mask_nxt_s  = 4'b0000;
         dm_wdata_nxt_s = 32'h0000_0000;
      end else begin
         dm_wdata_nxt_s = dm_wdata_nxt_s;
      end
   end

   // Output registers
   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         dm_addr_r     <= 32'h0000_0000;
         dm_req_r      <= 1'b0;
         dm_wr_r       <= 1'b0;
         dm_mask_r     <= 4'b0000;
         dm_wdata_r    <= 32'h0000_0000;
         lu_size_r     <= 2'b00;
         lu_offset_r   <= 2'b00;
         lu_unsigned_r <= 1'b0;
         misaligned_r  <= 1'b0;
         bus_err_r     <= 1'b0;
      end else begin
         dm_addr_r     <= dm_addr_nxt_s;
         dm_req_r      <= dm_req_nxt_s;
         dm_wr_r       <= dm_wr_nxt_s;
         dm_mask_r     <= dm_mask_nxt_s;
         dm_wdata_r    <= dm_wdata_nxt_s;
         lu_size_r     <= lu_size_nxt_s;
         lu_offset_r   <= lu_offset_nxt_s;
         lu_unsigned_r <= lu_unsigned_nxt_s;
         misaligned_r  <= misaligned_nxt_s;
         bus_err_r     <= bus_err_nxt_s;
      end
   end

   assign dm_addr_out     = dm_addr_r;
   assign dm_req_out      = dm_req_r;
   assign dm_wr_out       = dm_wr_r;
   assign dm_wr_mask_out  = dm_mask_r;
   assign dm_wdata_out    = dm_wdata_r;
   assign lu_size_out     = lu_size_r;
   assign lu_offset_out   = lu_offset_r;
   assign lu_unsigned_out = lu_unsigned_r;
   assign misaligned_out  = misaligned_r;
   assign bus_err_out     = bus_err_r;
   // Combinational outputs are forced low while reset is held, even with a request pending
   assign stall_out       = ~ms_riscv32_mp_rst_in & (accept_s | (state_r != ST_IDLE));
   assign lu_valid_out    = ~ms_riscv32_mp_rst_in & done_s & ~dm_resp_in & ~dm_wr_r;

endmodule

// File: tb/tb_msrv32_dmem_access_ctrl.sv
// Directed scoreboard bench for msrv32_dmem_access_ctrl: bus and load-unit expectations
// are queued when a request is driven and compared when the DUT presents them.
module tb_msrv32_dmem_access_ctrl;
   import msrv32_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_req = 1'b0, st_req = 1'b0, uns = 1'b0, dm_ready = 1'b0, dm_resp = 1'b0;
   logic [31:0] iadder = 32'h0, st_data = 32'h0;
   logic [1:0]  size = 2'b00;
   logic [31:0] dm_addr_out, dm_wdata_out;
   logic        dm_req_out, dm_wr_out, lu_unsigned_out, lu_valid_out;
   logic        stall_out, misaligned_out, bus_err_out;
   logic [3:0]  dm_wr_mask_out;
   logic [1:0]  lu_size_out, lu_offset_out;

   typedef struct packed { logic wr; logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; } bus_exp_t;
   typedef struct packed { logic [1:0] size; logic [1:0] off; logic uns; } lu_exp_t;
   bus_exp_t bus_q[$];
   lu_exp_t  lu_q[$];

   int checks = 0, errors = 0;
   int r_stall, r_err, r_valid, r_misal, r_req;

   msrv32_dmem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .ld_req_in       (ld_req),
      .st_req_in       (st_req),
      .iadder_in       (iadder),
      .size_in         (size),
      .unsigned_in     (uns),
      .st_data_in      (st_data),
      .dm_ready_in     (dm_ready),
      .dm_resp_in      (dm_resp),
      .dm_addr_out     (dm_addr_out),
      .dm_req_out      (dm_req_out),
      .dm_wr_out       (dm_wr_out),
      .dm_wr_mask_out  (dm_wr_mask_out),
      .dm_wdata_out    (dm_wdata_out),
      .lu_size_out     (lu_size_out),
      .lu_offset_out   (lu_offset_out),
      .lu_unsigned_out (lu_unsigned_out),
      .lu_valid_out    (lu_valid_out),
      .stall_out       (stall_out),
      .misaligned_out  (misaligned_out),
      .bus_err_out     (bus_err_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_bus(input logic wr, input logic [31:0] a, input logic [3:0] m, input logic [31:0] w);
      bus_exp_t e;
      e.wr = wr; e.addr = a; e.mask = m; e.wdata = w;
      bus_q.push_back(e);
   endtask

   task automatic push_lu(input logic [1:0] s, input logic [1:0] o, input logic u);
      lu_exp_t e;
      e.size = s; e.off = o; e.uns = u;
      lu_q.push_back(e);
   endtask

   // Bus monitor: compare the address-phase outputs on the first cycle of each request
   initial begin : bus_mon
      logic prev_req;
      bus_exp_t e;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (dm_req_out && !prev_req) begin
            chk("bus_q_depth", 32'(bus_q.size()), 32'd1);
            if (bus_q.size() > 0) begin
               e = bus_q.pop_front();
               chk("bus_wr",    32'(dm_wr_out), 32'(e.wr));
               chk("bus_addr",  dm_addr_out, e.addr);
               chk("bus_mask",  32'(dm_wr_mask_out), 32'(e.mask));
               chk("bus_wdata", dm_wdata_out, e.wdata);
            end
         end
         prev_req = dm_req_out;
      end
   end

   // Load-unit monitor: compare registered size/offset/signedness on each valid pulse
   initial begin : lu_mon
      lu_exp_t e;
      forever begin
         @(negedge clk);
         if (lu_valid_out) begin
            chk("lu_q_depth", 32'(lu_q.size()), 32'd1);
            if (lu_q.size() > 0) begin
               e = lu_q.pop_front();
               chk("lu_size", 32'(lu_size_out), 32'(e.size));
               chk("lu_off",  32'(lu_offset_out), 32'(e.off));
               chk("lu_uns",  32'(lu_unsigned_out), 32'(e.uns));
            end
         end
      end
   end

   task automatic sample();
      r_stall += int'(stall_out);
      r_err   += int'(bus_err_out);
      r_valid += int'(lu_valid_out);
      r_misal += int'(misaligned_out);
      r_req   += int'(dm_req_out);
   endtask

   // One request cycle, then run until stall drops; tallies stall cycles and pulses
   task automatic txn(input logic ld, input logic st, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] d, input int data_wait,
                      input logic stuck, input logic resp);
      int   dwait;
      logic started, expired;
      r_stall = 0; r_err = 0; r_valid = 0; r_misal = 0; r_req = 0;
      dwait = 0; started = 1'b0; expired = 1'b1;
      @(posedge clk); #1;
      ld_req = ld; st_req = st; iadder = a; size = sz; uns = u; st_data = d;
      dm_ready = 1'b0; dm_resp = 1'b0;
      @(negedge clk); sample();
      for (int c = 0; c < 64; c++) begin
         @(posedge clk); #1;
         ld_req = 1'b0; st_req = 1'b0; iadder = 32'h0; size = 2'b00; uns = 1'b0; st_data = 32'h0;
         dm_ready = 1'b0; dm_resp = 1'b0;
         if (dm_req_out) begin
            started = 1'b1;
            dm_ready = !stuck;
         end else if (started) begin
            if (!stuck && dwait >= data_wait) begin
               dm_ready = 1'b1;
               dm_resp = resp;
            end
            dwait++;
         end
         @(negedge clk); sample();
         if (!stall_out) begin
            expired = 1'b0;
            break;
         end
      end
      chk("txn_bound", 32'(expired), 32'd0);
      dm_ready = 1'b0; dm_resp = 1'b0;
   endtask

   initial begin
      // Reset with a pending aligned request: everything, including stall, stays low
      ld_req = 1'b1; size = SZ_WORD; iadder = 32'h0000_0010;
      @(negedge clk);
      chk("rst0_stall", 32'(stall_out), 32'd0);
      chk("rst0_addr",  dm_addr_out, 32'd0);
      chk("rst0_misc",  32'({dm_req_out, dm_wr_out, dm_wr_mask_out, lu_size_out, lu_offset_out,
                              lu_unsigned_out, lu_valid_out, misaligned_out, bus_err_out}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; ld_req = 1'b0; size = 2'b00; iadder = 32'h0;

      // Word store, zero wait states
      push_bus(1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
      txn(1'b0, 1'b1, 32'h0000_0100, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
      chk("ws_stall", r_stall, 3);
      chk("ws_pulses", 32'(r_err + r_valid + r_misal), 32'd0);
      chk("ws_req", r_req, 1);
      chk("ws_idle_req", 32'(dm_req_out), 32'd0);

      // Byte store to lane 3
      push_bus(1'b1, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5);
      txn(1'b0, 1'b1, 32'h0000_0203, SZ_BYTE, 1'b0, 32'h0000_00A5, 0, 1'b0, 1'b0);
      chk("bs_stall", r_stall, 3);
      chk("bs_misal", r_misal, 0);

      // Half store to upper half
      push_bus(1'b1, 32'h0000_0504, 4'b1100, 32'h1234_1234);
      txn(1'b0, 1'b1, 32'h0000_0506, SZ_HALF, 1'b0, 32'hCAFE_1234, 0, 1'b0, 1'b0);
      chk("hs_stall", r_stall, 3);

      // Unsigned half load with two DATA wait states
      push_bus(1'b0, 32'h0000_0300, 4'b0000, 32'h0);
      push_lu(SZ_HALF, 2'd2, 1'b1);
      txn(1'b1, 1'b0, 32'h0000_0302, SZ_HALF, 1'b1, 32'h0, 2, 1'b0, 1'b0);
      chk("hl_stall", r_stall, 5);
      chk("hl_valid", r_valid, 1);
      chk("hl_err", r_err, 0);

      // Misaligned word load: rejected, no bus activity, load-unit fields untouched
      txn(1'b1, 1'b0, 32'h0000_0401, SZ_WORD, 1'b0, 32'h0, 0, 1'b0, 1'b0);
      chk("ma_misal", r_misal, 1);
      chk("ma_req", r_req, 0);
      chk("ma_stall", r_stall, 0);
      chk("ma_lu_hold", 32'({lu_size_out, lu_offset_out, lu_unsigned_out}), 32'({SZ_HALF, 2'd2, 1'b1}));

      // Signed byte load at offset 1
      push_bus(1'b0, 32'h0000_0800, 4'b0000, 32'h0);
      push_lu(SZ_BYTE, 2'd1, 1'b0);
      txn(1'b1, 1'b0, 32'h0000_0801, SZ_BYTE, 1'b0, 32'h0, 0, 1'b0, 1'b0);
      chk("bl_valid", r_valid, 1);

      // Load with ready stuck low: timeout abort
      push_bus(1'b0, 32'h0000_0600, 4'b0000, 32'h0);
      txn(1'b1, 1'b0, 32'h0000_0600, SZ_WORD, 1'b0, 32'h0, 0, 1'b1, 1'b0);
      chk("to_stall", r_stall, TO + 1);
      chk("to_err", r_err, 1);
      chk("to_valid", r_valid, 0);
      chk("to_addr_clr", dm_addr_out, 32'd0);
      chk("to_req_clr", 32'(dm_req_out), 32'd0);

      // Error response in DATA
      push_bus(1'b0, 32'h0000_0700, 4'b0000, 32'h0);
      txn(1'b1, 1'b0, 32'h0000_0700, SZ_WORD, 1'b0, 32'h0, 0, 1'b0, 1'b1);
      chk("er_err", r_err, 1);
      chk("er_valid", r_valid, 0);
      chk("er_stall", r_stall, 3);

      // Reset during DATA with a new request pending
      push_bus(1'b0, 32'h0000_0900, 4'b0000, 32'h0);
      @(posedge clk); #1;
      ld_req = 1'b1; iadder = 32'h0000_0902; size = SZ_HALF; uns = 1'b1;
      @(posedge clk); #1;
      ld_req = 1'b0; dm_ready = 1'b1;
      @(posedge clk); #1;
      dm_ready = 1'b0;
      chk("pre_rst_stall", 32'(stall_out), 32'd1);
      chk("pre_rst_req", 32'(dm_req_out), 32'd0);
      ld_req = 1'b1; iadder = 32'h0000_0A00; size = SZ_WORD;
      rst = 1'b1;
      #1;
      chk("mrst_addr", dm_addr_out, 32'd0);
      chk("mrst_stall", 32'(stall_out), 32'd0);
      chk("mrst_misc", 32'({dm_req_out, dm_wr_out, dm_wr_mask_out, lu_size_out, lu_offset_out,
                             lu_unsigned_out, lu_valid_out, misaligned_out, bus_err_out}), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mrst_err", 32'(bus_err_out), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; ld_req = 1'b0; iadder = 32'h0; size = 2'b00; uns = 1'b0;

      // Simultaneous load and store: store only
      push_bus(1'b1, 32'h0000_0A00, 4'b1111, 32'h55AA_55AA);
      txn(1'b1, 1'b1, 32'h0000_0A00, SZ_WORD, 1'b1, 32'h55AA_55AA, 0, 1'b0, 1'b0);
      chk("ls_stall", r_stall, 3);
      chk("ls_valid", r_valid, 0);
      chk("ls_req", r_req, 1);

      @(negedge clk);
      chk("bus_q_left", 32'(bus_q.size()), 32'd0);
      chk("lu_q_left", 32'(lu_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
